shift_accum_sequencer: RTL and testbench

SHIFT_ACCUM_SEQUENCER -- requirements
Module: shift_accum_sequencer

---
 rtl/shift_accum_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_shift_accum_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_accum_sequencer.sv
// shift_accum_sequencer: captures NUM_BITS bit-frames into an external
// shift accumulator (one WRITE per pixel), then reads every address back
// and delivers the low NUM_BITS of each word as a code in address order.
module shift_accum_sequencer #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 1024,
    parameter int NUM_BITS = 8
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     start_in,
    input  logic                     pixel_valid_in,
    input  logic                     pixel_bit_in,
    output logic [$clog2(DEPTH)-1:0] accum_addr_out,
    output logic                     accum_summand_out,
    output logic                     accum_request_type_out,
    output logic                     accum_request_valid_out,
    input  logic [WIDTH-1:0]         accum_read_in,
    input  logic                     accum_request_type_in,
    input  logic                     accum_result_valid_in,
    output logic [NUM_BITS-1:0]      code_out,
    output logic [$clog2(DEPTH)-1:0] code_addr_out,
    output logic                     code_valid_out,
    input  logic                     code_ready_in,
    output logic                     busy_out,
    output logic                     done_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);
    localparam logic [FW-1:0] LAST_FRAME = FW'(NUM_BITS - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_DRAIN   = 2'd2;
    localparam logic [1:0] S_READOUT = 2'd3;

    localparam logic REQ_READ  = 1'b0;
    localparam logic REQ_WRITE = 1'b1;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] pix_q, pix_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          drain_q, drain_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic          rd_done_q, rd_done_d;
    logic [AW-1:0] ret_addr_q, ret_addr_d;
    logic [2:0]    outst_q, outst_d;

    logic          req_valid_q, req_valid_d;
    logic          req_type_q, req_type_d;
    logic [AW-1:0] req_addr_q, req_addr_d;
    logic          req_summand_q, req_summand_d;

    logic [AW-1:0]       fifo_addr_q [4];
    logic [NUM_BITS-1:0] fifo_code_q [4];
    logic [1:0]          wr_ptr_q, rd_ptr_q;
    logic [2:0]          fifo_cnt_q;

    logic       push, pop, issue, last_code;
    logic [3:0] credit_used;
    logic       unused_read_bits;

    // Only the low NUM_BITS of the returned word form the code.
    assign unused_read_bits = ^accum_read_in;

    assign push        = accum_result_valid_in && (accum_request_type_in == REQ_READ)
                         && (state_q == S_READOUT);
    assign code_valid_out = (fifo_cnt_q != 3'd0);
    assign pop         = code_valid_out && code_ready_in;
    assign code_out    = fifo_code_q[rd_ptr_q];
    assign code_addr_out = fifo_addr_q[rd_ptr_q];
    assign credit_used = {1'b0, outst_q} + {1'b0, fifo_cnt_q};
    assign issue       = (state_q == S_READOUT) && !rd_done_q && (credit_used < 4'd4);
    assign last_code   = pop && (code_addr_out == LAST_ADDR);

    assign busy_out = (state_q != S_IDLE);
    assign done_out = (state_q == S_READOUT) && last_code;

    assign accum_addr_out          = req_addr_q;
    assign accum_summand_out       = req_summand_q;
    assign accum_request_type_out  = req_type_q;
    assign accum_request_valid_out = req_valid_q;

    // Next-state logic for the sequencer, counters and the request register.
    always_comb begin
        state_d       = state_q;
        pix_d         = pix_q;
        frame_d       = frame_q;
        drain_d       = drain_q;
        rd_addr_d     = rd_addr_q;
        rd_done_d     = rd_done_q;
        ret_addr_d    = ret_addr_q;
        req_valid_d   = 1'b0;
        req_type_d    = req_type_q;
        req_addr_d    = req_addr_q;
        req_summand_d = req_summand_q;
        // Reads come back in issue order, so the returned address is a counter.
        outst_d       = outst_q + 3'(issue) - 3'(push);
        if (push) begin
            ret_addr_d = ret_addr_q + AW'(1);
        end
        case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    state_d = S_CAPTURE;
                    pix_d   = '0;
                    frame_d = '0;
                end
            end
            S_CAPTURE: begin
                if (pixel_valid_in) begin
                    req_valid_d   = 1'b1;
                    req_type_d    = REQ_WRITE;
                    req_addr_d    = pix_q;
                    req_summand_d = pixel_bit_in;
                    if (pix_q == LAST_ADDR) begin
                        pix_d = '0;
                        if (frame_q == LAST_FRAME) begin
                            state_d = S_DRAIN;
                            frame_d = '0;
                            drain_d = 1'b0;
                        end else begin
                            frame_d = frame_q + FW'(1);
                        end
                    end else begin
                        pix_d = pix_q + AW'(1);
                    end
                end
            end
            S_DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d    = S_READOUT;
                    rd_addr_d  = '0;
                    rd_done_d  = 1'b0;
                    ret_addr_d = '0;
                end
            end
            S_READOUT: begin
                if (issue) begin
                    req_valid_d = 1'b1;
                    req_type_d  = REQ_READ;
                    req_addr_d  = rd_addr_q;
                    if (rd_addr_q == LAST_ADDR) begin
                        rd_done_d = 1'b1;
                    end else begin
                        rd_addr_d = rd_addr_q + AW'(1);
                    end
                end
                if (last_code) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and request registers; reset abandons any run in flight.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q       <= S_IDLE;
            pix_q         <= '0;
            frame_q       <= '0;
            drain_q       <= 1'b0;
            rd_addr_q     <= '0;
            rd_done_q     <= 1'b0;
            ret_addr_q    <= '0;
            outst_q       <= '0;
            req_valid_q   <= 1'b0;
            req_type_q    <= 1'b0;
            req_addr_q    <= '0;
            req_summand_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pix_q         <= pix_d;
            frame_q       <= frame_d;
            drain_q       <= drain_d;
            rd_addr_q     <= rd_addr_d;
            rd_done_q     <= rd_done_d;
            ret_addr_q    <= ret_addr_d;
            outst_q       <= outst_d;
            req_valid_q   <= req_valid_d;
            req_type_q    <= req_type_d;
            req_addr_q    <= req_addr_d;
            req_summand_q <= req_summand_d;
        end
    end

    // Four-entry code FIFO of {address, code}; push and pop may coincide.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int unsigned i = 0; i < 4; i++) begin
                fifo_addr_q[i] <= '0;
                fifo_code_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) begin
                fifo_addr_q[wr_ptr_q] <= ret_addr_q;
                fifo_code_q[wr_ptr_q] <= accum_read_in[NUM_BITS-1:0];
                wr_ptr_q              <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            fifo_cnt_q <= fifo_cnt_q + 3'(push) - 3'(pop);
        end
    end

    // The read credit limit must keep the FIFO from ever overflowing.
    a_no_overflow: assert property (@(posedge clk_in) disable iff (rst_in)
        !(push && (fifo_cnt_q == 3'd4)));

endmodule

// File: tb/tb_shift_accum_sequencer.sv
// Self-checking bench for shift_accum_sequencer with a 2-cycle accumulator model.
module tb_shift_accum_sequencer;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int NUM_BITS = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, pv, pb, ready;
    logic [1:0] accum_addr, code_addr;
    logic accum_summand, accum_type, accum_valid;
    logic [2:0] code;
    logic code_valid, busy, done;

    // Accumulator model: each word shifts in the summand on WRITE; results
    // come back two cycles after the request.
    logic [7:0] mem [4];
    logic preset_ff = 1'b0;
    logic s1_v = 1'b0, s1_t = 1'b0;
    logic [1:0] s1_a = '0;
    logic res_v = 1'b0, res_t = 1'b0;
    logic [7:0] res_d = '0;

    shift_accum_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_BITS(NUM_BITS)) dut (
        .clk_in(clk), .rst_in(rst), .start_in(start),
        .pixel_valid_in(pv), .pixel_bit_in(pb),
        .accum_addr_out(accum_addr), .accum_summand_out(accum_summand),
        .accum_request_type_out(accum_type), .accum_request_valid_out(accum_valid),
        .accum_read_in(res_d), .accum_request_type_in(res_t),
        .accum_result_valid_in(res_v),
        .code_out(code), .code_addr_out(code_addr), .code_valid_out(code_valid),
        .code_ready_in(ready), .busy_out(busy), .done_out(done)
    );

    always @(posedge clk) begin
        s1_v  <= accum_valid;
        s1_t  <= accum_type;
        s1_a  <= accum_addr;
        res_v <= s1_v;
        res_t <= s1_t;
        res_d <= mem[s1_a];
        if (preset_ff) begin
            for (int i = 0; i < 4; i++) mem[i] <= 8'hFF;
        end else if (accum_valid && accum_type) begin
            mem[accum_addr] <= {mem[accum_addr][6:0], accum_summand};
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
        end
    endtask

    typedef struct {
        int addr;
        int bitv;
        int cyc;
    } wr_t;

    wr_t exp_wr[$];
    int exp_caddr[$];
    int exp_cval[$];
    int cyc = 0;
    int run_id = 0;
    int rd_issued = 0, rd_delivered = 0, done_cnt = 0;
    int got_code [4];

    always @(posedge clk) cyc <= cyc + 1;

    // Compare process: checks every request, handshake and done pulse.
    int last_run = 0;
    logic prev_stall = 1'b0;
    int prev_addr = 0, prev_code = 0;
    always @(negedge clk) begin
        wr_t e;
        int ea, ev;
        logic hs;
        if (rst) begin
            exp_wr.delete();
            exp_caddr.delete();
            exp_cval.delete();
            prev_stall = 1'b0;
        end else begin
            if (run_id != last_run) begin
                last_run = run_id;
                rd_issued = 0;
                rd_delivered = 0;
                for (int i = 0; i < 4; i++) got_code[i] = -1;
            end
            if (accum_valid && accum_type) begin
                chk("wr_expected", int'(exp_wr.size() != 0), 1);
                if (exp_wr.size() != 0) begin
                    e = exp_wr.pop_front();
                    chk("wr_addr", int'(accum_addr), e.addr);
                    chk("wr_summand", int'(accum_summand), e.bitv);
                    chk("wr_latency", cyc, e.cyc + 1);
                end
            end
            if (accum_valid && !accum_type) begin
                chk("rd_in_range", int'(rd_issued < DEPTH), 1);
                chk("rd_addr", int'(accum_addr), rd_issued);
                rd_issued++;
                chk("rd_credit", int'((rd_issued - rd_delivered) <= 4), 1);
            end
            hs = code_valid && ready;
            chk("done", int'(done), int'(hs && (rd_delivered == DEPTH - 1)));
            if (prev_stall) begin
                chk("stall_valid", int'(code_valid), 1);
                chk("stall_addr", int'(code_addr), prev_addr);
                chk("stall_code", int'(code), prev_code);
            end
            if (hs) begin
                chk("code_expected", int'(exp_caddr.size() != 0), 1);
                if (exp_caddr.size() != 0) begin
                    ea = exp_caddr.pop_front();
                    ev = exp_cval.pop_front();
                    chk("code_addr", int'(code_addr), ea);
                    chk("code_val", int'(code), ev);
                end
                got_code[code_addr] = int'(code);
                rd_delivered++;
            end
            if (done) done_cnt++;
            prev_stall = code_valid && !ready;
            prev_addr = int'(code_addr);
            prev_code = int'(code);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_outputs"}, int'({accum_addr, accum_summand, accum_type, accum_valid,
                                     code, code_addr, code_valid, busy, done}), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    // Capture one run; abort_at >= 0 asserts reset in place of that pixel.
    task automatic capture(input logic [3:0] p0, input logic [3:0] p1, input logic [3:0] p2,
                           input bit gaps, input bit start_mid, input int abort_at);
        logic [3:0] pat [3];
        int idx;
        pat[0] = p0; pat[1] = p1; pat[2] = p2;
        run_id++;
        for (int a = 0; a < DEPTH; a++) begin
            exp_caddr.push_back(a);
            exp_cval.push_back((int'(p0[a]) << 2) | (int'(p1[a]) << 1) | int'(p2[a]));
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_capture", int'(busy), 1);
        for (int f = 0; f < NUM_BITS; f++) begin
            for (int a = 0; a < DEPTH; a++) begin
                idx = f * DEPTH + a;
                if (idx == abort_at) begin
                    pv = 1'b0;
                    rst = 1'b1;
                    check_reset_outputs("abort");
                    tick();
                    rst = 1'b0;
                    return;
                end
                if (gaps && (idx % 3 == 1)) begin
                    pv = 1'b0;
                    tick();
                    tick();
                end
                if (start_mid && idx == 5) start = 1'b1;
                pv = 1'b1;
                pb = pat[f][a];
                exp_wr.push_back('{a, int'(pb), cyc});
                tick();
                start = 1'b0;
            end
        end
        pv = 1'b0;
        pb = 1'b0;
    endtask

    task automatic readout(input int stall, input int e0, input int e1, input int e2, input int e3);
        int d0, t;
        d0 = done_cnt;
        if (stall > 0) begin
            ready = 1'b0;
            repeat (stall + 2) tick();
            chk("stall_reads", rd_issued, 4);
            chk("stall_delivered", rd_delivered, 0);
            chk("stall_code_valid", int'(code_valid), 1);
            ready = 1'b1;
        end
        t = 0;
        while (done_cnt == d0 && t < 100) begin
            tick();
            t++;
        end
        chk("done_seen", done_cnt, d0 + 1);
        tick();
        tick();
        chk("done_once", done_cnt, d0 + 1);
        chk("busy_idle", int'(busy), 0);
        chk("codes_delivered", rd_delivered, DEPTH);
        chk("wr_queue_empty", exp_wr.size(), 0);
        chk("lit_code0", got_code[0], e0);
        chk("lit_code1", got_code[1], e1);
        chk("lit_code2", got_code[2], e2);
        chk("lit_code3", got_code[3], e3);
    endtask

    initial begin
        int d0;
        rst = 1'b1; start = 1'b0; pv = 1'b0; pb = 1'b0; ready = 1'b1;
        preset_ff = 1'b1;
        tick();
        check_reset_outputs("reset");
        preset_ff = 1'b0;
        tick();
        rst = 1'b0;

        // Pixels and no start while idle: nothing may be requested.
        pv = 1'b1; pb = 1'b1;
        tick(); tick(); tick();
        pv = 1'b0; pb = 1'b0;
        chk("idle_busy", int'(busy), 0);

        // Basic pattern: addr0 = 1,0,1 and addr3 = 1,1,0.
        capture(4'b1001, 4'b1000, 4'b0001, 1'b0, 1'b0, -1);
        readout(0, 5, 0, 0, 6);

        // Gaps, start pulsed mid-capture and 10 cycles of backpressure.
        capture(4'b0110, 4'b0011, 4'b1011, 1'b1, 1'b1, -1);
        readout(10, 3, 7, 4, 1);

        // Residue: words preloaded to 0xFF, then an all-zero capture.
        preset_ff = 1'b1;
        tick();
        preset_ff = 1'b0;
        tick();
        capture(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, -1);
        readout(0, 0, 0, 0, 0);

        // Reset during frame 1, then a full fresh run.
        d0 = done_cnt;
        capture(4'b1001, 4'b1000, 4'b0001, 1'b0, 1'b0, 5);
        repeat (4) tick();
        chk("abort_no_done", done_cnt, d0);
        chk("abort_idle", int'(busy), 0);
        capture(4'b1001, 4'b1000, 4'b0001, 1'b0, 1'b0, -1);
        readout(0, 5, 0, 0, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
